frame_scanout: RTL and testbench



---
 rtl/buffer_config_pkg.sv | 16 +
 rtl/display_config_pkg.sv | 29 ++
 rtl/types_pkg.sv | 8 +
 rtl/vga_timing_gen.sv | 75 +++++++
 rtl/frame_scanout.sv | 142 ++++++++++++++
 tb/tb_frame_scanout.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/buffer_config_pkg.sv
// rtl/buffer_config_pkg.sv - frame buffer geometry descriptors
// Purpose: buffer_config_t and the standard 160x120x12 buffer instance.
package buffer_config_pkg;

    typedef struct packed {
        int unsigned addr_width;
        int unsigned size;
        int unsigned width;
        int unsigned height;
    } buffer_config_t;

    localparam buffer_config_t BUFFER_160x120x12 = '{
        addr_width: 15, size: 19200, width: 160, height: 120
    };

endpackage

// File: rtl/display_config_pkg.sv
// rtl/display_config_pkg.sv - display timing descriptors
// Purpose: vga_timing_t, the 640x480@60 timing set and total-length helpers.
package display_config_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    function automatic int unsigned h_total(input vga_timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int unsigned v_total(input vga_timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

endpackage

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared pixel types
// Purpose: colour type used between the frame buffer and the scanout pins.
package types_pkg;

    // R4G4B4, red in the top nibble.
    typedef logic [11:0] color_t;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - horizontal/vertical raster counters and S0 decode
// Purpose: free-running h/v counters with combinational decode of the S0 position.
// Ports:
//   clk_i, rst_i      pixel clock, async active-high reset
//   de_o              position is inside the active area
//   hsync_n_o         horizontal sync, active low
//   vsync_n_o         vertical sync, active low
//   vblank_o          v counter is past the active lines
//   frame_start_o     first pixel of the frame (h=0, v=0)
//   line_end_o        last active column of any line (h=h_active-1)
//   frame_end_o       last cycle of the frame; both counters wrap next edge
module vga_timing_gen
    import display_config_pkg::*;
#(
    parameter vga_timing_t TIMING = VGA_640x480
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic de_o,
    output logic hsync_n_o,
    output logic vsync_n_o,
    output logic vblank_o,
    output logic frame_start_o,
    output logic line_end_o,
    output logic frame_end_o
);

    localparam int unsigned H_TOTAL = h_total(TIMING);
    localparam int unsigned V_TOTAL = v_total(TIMING);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(TIMING.h_active);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(TIMING.h_active - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(TIMING.h_active + TIMING.h_fp);
    localparam logic [HW-1:0] H_SYNC_END = HW'(TIMING.h_active + TIMING.h_fp + TIMING.h_sync);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(TIMING.v_active);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(TIMING.v_active + TIMING.v_fp);
    localparam logic [VW-1:0] V_SYNC_END = VW'(TIMING.v_active + TIMING.v_fp + TIMING.v_sync);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_last, v_last;

    always_comb begin
        h_last  = (h_cnt_q == H_LAST);
        v_last  = (v_cnt_q == V_LAST);
        h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign de_o          = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hsync_n_o     = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
    assign vsync_n_o     = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
    assign vblank_o      = (v_cnt_q >= V_ACT);
    assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign line_end_o    = (h_cnt_q == H_ACT_LAST);
    assign frame_end_o   = h_last && v_last;

endmodule

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - frame buffer scanout with integer upscaling to VGA pins
// Purpose: reads the frame buffer in raster order, each buffer pixel repeated
//          SCALE times per axis, and re-aligns data with delayed sync/blank.
// Ports:
//   clk_i, rst_i      pixel clock, async active-high reset
//   read_addr_o       frame-buffer read address (S1, registered)
//   read_data_i       frame-buffer data, valid one cycle after read_addr_o
//   hsync_o, vsync_o  syncs, active low, registered (S3)
//   video_active_o    data enable aligned with rgb_o
//   rgb_o             R4G4B4 pixel, 0 outside the active area
//   frame_start_o     one-cycle pulse with the first active pixel of a frame
//   vblank_o          undelayed vertical blank for upstream buffer swap
module frame_scanout
    import types_pkg::*;
    import buffer_config_pkg::*;
    import display_config_pkg::*;
#(
    parameter buffer_config_t BUFFER_CONFIG = BUFFER_160x120x12,
    parameter vga_timing_t    TIMING        = VGA_640x480,
    parameter int unsigned    SCALE         = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    output logic [BUFFER_CONFIG.addr_width-1:0] read_addr_o,
    input  color_t                              read_data_i,
    output logic                                hsync_o,
    output logic                                vsync_o,
    output logic                                video_active_o,
    output color_t                              rgb_o,
    output logic                                frame_start_o,
    output logic                                vblank_o
);

    localparam int AW   = int'(BUFFER_CONFIG.addr_width);
    localparam int FB_W = int'(BUFFER_CONFIG.width);
    localparam int CW   = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int SW   = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(FB_W);

    if ((TIMING.h_active != BUFFER_CONFIG.width * SCALE) ||
        (TIMING.v_active != BUFFER_CONFIG.height * SCALE)) begin : g_bad_scale
        $error("frame_scanout: active area is not the buffer size times SCALE");
    end

    logic de_s0, hsync_n_s0, vsync_n_s0, fs_s0, line_end, frame_end, vblank;

    vga_timing_gen #(
        .TIMING(TIMING)
    ) u_timing (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .de_o         (de_s0),
        .hsync_n_o    (hsync_n_s0),
        .vsync_n_o    (vsync_n_s0),
        .vblank_o     (vblank),
        .frame_start_o(fs_s0),
        .line_end_o   (line_end),
        .frame_end_o  (frame_end)
    );

    // Address scaler: row_base advances by one buffer row every SCALE lines and
    // col by one every SCALE pixels, so the address is a plain add.
    logic [SW-1:0] x_sub_q, x_sub_d, y_sub_q, y_sub_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] read_addr_q, read_addr_d;

    always_comb begin
        x_sub_d     = x_sub_q;
        col_d       = col_q;
        y_sub_d     = y_sub_q;
        row_base_d  = row_base_q;
        read_addr_d = read_addr_q;
        if (de_s0) begin
            read_addr_d = row_base_q + AW'(col_q);
            if (x_sub_q == SUB_LAST) begin
                x_sub_d = '0;
                col_d   = col_q + CW'(1);
            end else begin
                x_sub_d = x_sub_q + SW'(1);
            end
        end
        // The line-end clear must override the col increment on the last pixel.
        if (line_end) begin
            x_sub_d = '0;
            col_d   = '0;
            if (!vblank) begin
                if (y_sub_q == SUB_LAST) begin
                    y_sub_d    = '0;
                    row_base_d = row_base_q + ROW_STEP;
                end else begin
                    y_sub_d = y_sub_q + SW'(1);
                end
            end
        end
        if (frame_end) begin
            y_sub_d    = '0;
            row_base_d = '0;
        end
    end

    // Index n of each shift register is the S0 decode delayed n+1 cycles;
    // bit 1 lines up with read_data_i (S2), bit 2 with the registered pins.
    logic [2:0] hs_sr_q, vs_sr_q, de_sr_q, fs_sr_q;
    color_t     rgb_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_sub_q     <= '0;
            col_q       <= '0;
            y_sub_q     <= '0;
            row_base_q  <= '0;
            read_addr_q <= '0;
            hs_sr_q     <= '1;
            vs_sr_q     <= '1;
            de_sr_q     <= '0;
            fs_sr_q     <= '0;
            rgb_q       <= '0;
        end else begin
            x_sub_q     <= x_sub_d;
            col_q       <= col_d;
            y_sub_q     <= y_sub_d;
            row_base_q  <= row_base_d;
            read_addr_q <= read_addr_d;
            hs_sr_q     <= {hs_sr_q[1:0], hsync_n_s0};
            vs_sr_q     <= {vs_sr_q[1:0], vsync_n_s0};
            de_sr_q     <= {de_sr_q[1:0], de_s0};
            fs_sr_q     <= {fs_sr_q[1:0], fs_s0};
            rgb_q       <= de_sr_q[1] ? read_data_i : '0;
        end
    end

    assign read_addr_o    = read_addr_q;
    assign hsync_o        = hs_sr_q[2];
    assign vsync_o        = vs_sr_q[2];
    assign video_active_o = de_sr_q[2];
    assign frame_start_o  = fs_sr_q[2];
    assign rgb_o          = rgb_q;
    assign vblank_o       = vblank;

endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - directed bench for frame_scanout (VGA and reduced geometry)
module tb_frame_scanout;
    import types_pkg::*;
    import buffer_config_pkg::*;
    import display_config_pkg::*;

    // Reduced geometry: 8x6 buffer, x4 -> 32x24 active, 48x30 total, 1440-cycle frame.
    localparam buffer_config_t SMALL_BUF = '{addr_width: 6, size: 48, width: 8, height: 6};
    localparam vga_timing_t SMALL_TIMING = '{
        h_active: 32, h_fp: 4, h_sync: 6, h_bp: 6,
        v_active: 24, v_fp: 2, v_sync: 2, v_bp: 2
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [14:0] ra_v, ap_v;
    logic [5:0]  ra_s, ap_s;
    color_t      rd_v, rd_s, rgb_v, rgb_s;
    logic        hs_v, vs_v, de_v, fs_v, vb_v;
    logic        hs_s, vs_s, de_s, fs_s, vb_s;

    frame_scanout dut_vga (
        .clk_i(clk), .rst_i(rst), .read_addr_o(ra_v), .read_data_i(rd_v),
        .hsync_o(hs_v), .vsync_o(vs_v), .video_active_o(de_v), .rgb_o(rgb_v),
        .frame_start_o(fs_v), .vblank_o(vb_v)
    );

    frame_scanout #(
        .BUFFER_CONFIG(SMALL_BUF), .TIMING(SMALL_TIMING), .SCALE(4)
    ) dut_small (
        .clk_i(clk), .rst_i(rst), .read_addr_o(ra_s), .read_data_i(rd_s),
        .hsync_o(hs_s), .vsync_o(vs_s), .video_active_o(de_s), .rgb_o(rgb_s),
        .frame_start_o(fs_s), .vblank_o(vb_s)
    );

    int n, n_checks, n_pass;
    bit scan_en, ff_mode;
    int hs_fall_v = -1, hs_len_v = -1, vs_fall_s = -1, vs_len_s = -1;
    int fs_first_s = -1, fs_second_s = -1;
    logic hs_v_prev, vs_s_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Pins expected k samples after reset release: {vblank, hsync, vsync, de, fs, rgb}.
    // vblank is undelayed (position k); the rest come from position k-3.
    function automatic logic [31:0] exp_pins(input vga_timing_t t, input int fbw, input int k,
                                             input bit ff);
        int ht, vt, ha, va, hsb, hse, vsb, vse, p, h, v, addr;
        logic vb, hs, vs, de, fs;
        logic [11:0] px;
        ht  = int'(h_total(t));
        vt  = int'(v_total(t));
        ha  = int'(t.h_active);
        va  = int'(t.v_active);
        hsb = int'(t.h_active + t.h_fp);
        hse = hsb + int'(t.h_sync);
        vsb = int'(t.v_active + t.v_fp);
        vse = vsb + int'(t.v_sync);
        vb  = ((k / ht) % vt) >= va;
        p   = k - 3;
        if (p < 0) return {15'd0, vb, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        h    = p % ht;
        v    = (p / ht) % vt;
        hs   = !(h >= hsb && h < hse);
        vs   = !(v >= vsb && v < vse);
        de   = (h < ha) && (v < va);
        fs   = (h == 0) && (v == 0);
        addr = (v / 4) * fbw + h / 4;
        px   = de ? (ff ? 12'hFFF : 12'(addr)) : 12'h000;
        return {15'd0, vb, hs, vs, de, fs, px};
    endfunction

    // read_addr after sample k holds the address of the last active position <= k-1.
    function automatic int exp_addr(input vga_timing_t t, input int fbw, input int k);
        int ht, vt, q, h, v;
        ht = int'(h_total(t));
        vt = int'(v_total(t));
        q  = k - 1;
        if (q < 0) return 0;
        h = q % ht;
        v = (q / ht) % vt;
        if (v >= int'(t.v_active)) begin
            h = int'(t.h_active) - 1;
            v = int'(t.v_active) - 1;
        end else if (h >= int'(t.h_active)) begin
            h = int'(t.h_active) - 1;
        end
        return (v / 4) * fbw + h / 4;
    endfunction

    task automatic scan();
        check($sformatf("vga_pins@%0d", n), {15'd0, vb_v, hs_v, vs_v, de_v, fs_v, rgb_v},
              exp_pins(VGA_640x480, 160, n, ff_mode));
        check($sformatf("vga_addr@%0d", n), 32'(ra_v), 32'(exp_addr(VGA_640x480, 160, n)));
        check($sformatf("small_pins@%0d", n), {15'd0, vb_s, hs_s, vs_s, de_s, fs_s, rgb_s},
              exp_pins(SMALL_TIMING, 8, n, ff_mode));
        check($sformatf("small_addr@%0d", n), 32'(ra_s), 32'(exp_addr(SMALL_TIMING, 8, n)));
    endtask

    // One clock; samples on the falling edge, then models the 1-cycle-latency RAMs
    // (data presented this cycle belongs to the address of the previous cycle).
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
        if (scan_en) begin
            scan();
            if (hs_v_prev && !hs_v && hs_fall_v < 0) hs_fall_v = n;
            if (!hs_v_prev && hs_v && hs_fall_v >= 0 && hs_len_v < 0) hs_len_v = n - hs_fall_v;
            if (vs_s_prev && !vs_s && vs_fall_s < 0) vs_fall_s = n;
            if (!vs_s_prev && vs_s && vs_fall_s >= 0 && vs_len_s < 0) vs_len_s = n - vs_fall_s;
            if (fs_s) begin
                if (fs_first_s < 0) fs_first_s = n;
                else if (fs_second_s < 0) fs_second_s = n;
            end
            hs_v_prev = hs_v;
            vs_s_prev = vs_s;
        end
        rd_v = ff_mode ? 12'hFFF : ap_v[11:0];
        rd_s = ff_mode ? 12'hFFF : {6'd0, ap_s};
        ap_v = ra_v;
        ap_s = ra_s;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic run_to_mod(input int m, input int r);
        for (int i = 0; i < m && (n % m) != r; i++) step();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_hs_v"},  32'(hs_v),  32'd1);
        check({tag, "_vs_v"},  32'(vs_v),  32'd1);
        check({tag, "_de_v"},  32'(de_v),  32'd0);
        check({tag, "_rgb_v"}, 32'(rgb_v), 32'd0);
        check({tag, "_fs_v"},  32'(fs_v),  32'd0);
        check({tag, "_ra_v"},  32'(ra_v),  32'd0);
        check({tag, "_vb_v"},  32'(vb_v),  32'd0);
        check({tag, "_hs_s"},  32'(hs_s),  32'd1);
        check({tag, "_vs_s"},  32'(vs_s),  32'd1);
        check({tag, "_de_s"},  32'(de_s),  32'd0);
        check({tag, "_rgb_s"}, 32'(rgb_s), 32'd0);
        check({tag, "_fs_s"},  32'(fs_s),  32'd0);
        check({tag, "_ra_s"},  32'(ra_s),  32'd0);
        check({tag, "_vb_s"},  32'(vb_s),  32'd0);
    endtask

    task automatic release_reset();
        rst       = 1'b0;
        n         = 0;
        scan_en   = 1'b1;
        hs_v_prev = hs_v;
        vs_s_prev = vs_s;
    endtask

    initial begin
        n = 0; n_checks = 0; n_pass = 0;
        scan_en = 1'b0; ff_mode = 1'b0;
        rd_v = '0; rd_s = '0; ap_v = '0; ap_s = '0;
        rst = 1'b1;

        repeat (5) step();
        reset_checks("rst");
        release_reset();
        check("ra_v_first", 32'(ra_v), 32'd0);

        run_to(2);    check("de_v_n2", 32'(de_v), 32'd0);
                      check("fs_v_n2", 32'(fs_v), 32'd0);
        run_to(3);    check("de_v_rise", 32'(de_v), 32'd1);
                      check("fs_v_rise", 32'(fs_v), 32'd1);
                      check("rgb_v_px0", 32'(rgb_v), 32'h000);
                      check("fs_s_rise", 32'(fs_s), 32'd1);
        run_to(4);    check("fs_v_fall", 32'(fs_v), 32'd0);
        run_to(7);    check("rgb_v_px4", 32'(rgb_v), 32'h001);
        run_to(640);  check("ra_v_line0_end", 32'(ra_v), 32'd159);
        run_to(1136); check("ra_s_max", 32'(ra_s), 32'd47);
        run_to(1151); check("vb_s_before", 32'(vb_s), 32'd0);
        run_to(1152); check("vb_s_after", 32'(vb_s), 32'd1);
        run_to(3201); check("ra_v_line4", 32'(ra_v), 32'd160);
        run_to(3300);
        check("hsync_fall", 32'(hs_fall_v), 32'd659);
        check("hsync_len", 32'(hs_len_v), 32'd96);
        check("vsync_fall_s", 32'(vs_fall_s), 32'd1251);
        check("vsync_len_s", 32'(vs_len_s), 32'd96);
        check("fs_first_s", 32'(fs_first_s), 32'd3);
        check("fs_period_s", 32'(fs_second_s - fs_first_s), 32'd1440);

        // Blanking: buffer data stuck at 0xFFF must never reach the pins in blank.
        ff_mode = 1'b1;
        scan_en = 1'b0;
        repeat (3) step();
        scan_en = 1'b1;
        run_to_mod(800, 703);
        check("blank_rgb_v", 32'(rgb_v), 32'h000);
        check("blank_de_v", 32'(de_v), 32'd0);
        run_to_mod(800, 103);
        check("active_rgb_v", 32'(rgb_v), 32'hFFF);
        check("active_de_v", 32'(de_v), 32'd1);
        run_to(4900);

        // Mid-frame reset of the reduced display at v=10, h=20.
        ff_mode = 1'b0;
        scan_en = 1'b0;
        repeat (3) step();
        scan_en = 1'b1;
        run_to_mod(1440, 500);
        check("pre_rst_de_s", 32'(de_s), 32'd1);
        rst = 1'b1;
        #1;
        reset_checks("midrst");
        scan_en = 1'b0;
        repeat (2) step();
        release_reset();
        run_to(1); check("mid_ra_s_n1", 32'(ra_s), 32'd0);
        run_to(2); check("mid_fs_s_n2", 32'(fs_s), 32'd0);
        run_to(3); check("mid_fs_s_n3", 32'(fs_s), 32'd1);
                   check("mid_fs_v_n3", 32'(fs_v), 32'd1);
        run_to(5); check("mid_ra_s_n5", 32'(ra_s), 32'd1);
                   check("mid_ra_v_n5", 32'(ra_v), 32'd1);
        run_to(1500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
